// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the RV32I core back end.
//   - funct3 encodings of the load instructions (LB/LH/LW/LBU/LHU)
//   - writeback FSM state type
//   - capture record for a load waiting on data memory
//   - helper deciding whether an instruction really writes the register bank
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int unsigned XLEN = 32;

    // Load width/sign codes (instruction funct3 field)
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } wb_state_e;

    // Everything the stage must remember about a load between accept and
    // the memory response.
    typedef struct packed {
        logic [4:0]      rd;
        logic            regwrite;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
    } wb_cap_t;

    // x0 is hard-wired to zero, so a write to it is suppressed at the source.
    function automatic logic rd_writable(input logic we, input logic [4:0] rd);
        return we && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// -----------------------------------------------------------------------------
// writeback_stage_if
// Bundles the signals around the writeback stage:
//   execute side    : ex_valid/ex_ready handshake plus instruction fields
//   data memory     : read request handshake and one-cycle read response
//   register bank   : single write port (regwrite/rdaddr/rddata)
//   hazard / status : pend_valid/pend_rd of the in-flight load, load_err pulse
// Modports:
//   slave  - the writeback stage itself
//   master - the environment (execute stage, memory, register bank)
// -----------------------------------------------------------------------------
interface writeback_stage_if;

    // execute -> writeback
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_regwrite;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic        ex_isload;
    logic [2:0]  ex_funct3;

    // data memory read port
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    // register bank write port
    logic        regwrite;
    logic [4:0]  rdaddr;
    logic [31:0] rddata;

    // hazard / status
    logic        pend_valid;
    logic [4:0]  pend_rd;
    logic        load_err;

    modport slave (
        input  ex_valid, ex_regwrite, ex_rd, ex_result, ex_isload, ex_funct3,
        output ex_ready,
        output mem_req_valid, mem_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output regwrite, rdaddr, rddata,
        output pend_valid, pend_rd, load_err
    );

    modport master (
        output ex_valid, ex_regwrite, ex_rd, ex_result, ex_isload, ex_funct3,
        input  ex_ready,
        input  mem_req_valid, mem_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  regwrite, rdaddr, rddata,
        input  pend_valid, pend_rd, load_err
    );

endinterface

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Purely combinational load data formatter and legality check.
//   funct3_i  : load width/sign code
//   addr_i    : low two bits of the byte address
//   word_i    : 32-bit little-endian memory word
//   data_o    : selected byte/halfword/word, sign- or zero-extended
//   err_o     : illegal funct3 or address misaligned for the access width
// Kept free of any stage state so the store path can share it.
// -----------------------------------------------------------------------------
module load_align
    import core_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o,
    output logic        err_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{addr_i, 3'b000} +: 8];
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
        data_o   = '0;
        err_o    = 1'b0;
        case (funct3_i)
            LB: begin
                data_o = {{24{byte_sel[7]}}, byte_sel};
            end
            LBU: begin
                data_o = {24'd0, byte_sel};
            end
            LH: begin
                data_o = {{16{half_sel[15]}}, half_sel};
                err_o  = addr_i[0];
            end
            LHU: begin
                data_o = {16'd0, half_sel};
                err_o  = addr_i[0];
            end
            LW: begin
                data_o = word_i;
                err_o  = (addr_i != 2'b00);
            end
            default: begin
                err_o  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
// Final stage of the RV32I pipeline. Accepts one retired instruction per
// ex_valid/ex_ready handshake:
//   - non-loads are written to the register bank one cycle after accept
//   - legal loads issue a word-aligned read, wait for the response, extract
//     the byte/halfword/word and write it the cycle after the response
//   - misaligned or illegal loads pulse load_err and are dropped
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (also abandons an in-flight load)
//   bus  : writeback_stage_if.slave (execute, data memory, register bank,
//          hazard/status signals)
// -----------------------------------------------------------------------------
module writeback_stage
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.slave  bus
);

    wb_state_e   state_q, state_d;
    wb_cap_t     cap_q, cap_d;

    logic        regwrite_q, regwrite_d;
    logic [4:0]  rdaddr_q, rdaddr_d;
    logic [31:0] rddata_q, rddata_d;
    logic        load_err_q, load_err_d;

    logic        ex_ready;
    logic        mem_req_valid;
    logic        pend_valid;
    logic [4:0]  pend_rd;
    logic        accept;

    logic [2:0]  la_funct3;
    logic [1:0]  la_addr;
    logic [31:0] la_data;
    logic        la_err;

    assign accept = bus.ex_valid && ex_ready;

    // One aligner serves both uses: in IDLE it judges the incoming load's
    // legality, in WAIT it formats the response for the captured load.
    assign la_funct3 = (state_q == IDLE) ? bus.ex_funct3     : cap_q.funct3;
    assign la_addr   = (state_q == IDLE) ? bus.ex_result[1:0] : cap_q.addr[1:0];

    load_align u_load_align (
        .funct3_i (la_funct3),
        .addr_i   (la_addr),
        .word_i   (bus.mem_rsp_data),
        .data_o   (la_data),
        .err_o    (la_err)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && bus.ex_isload && !la_err) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Responses are only looked at here, so a stray pulse in
                // IDLE or REQ has no effect.
                if (bus.mem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ex_ready      = (state_q == IDLE) && !rst;
        mem_req_valid = (state_q == REQ);
        pend_valid    = (state_q == REQ) || (state_q == WAIT);
        pend_rd       = pend_valid ? cap_q.rd : 5'd0;
    end

    // ------------------------------------------- capture / output registers
    always_comb begin
        cap_d      = cap_q;
        regwrite_d = 1'b0;
        rdaddr_d   = rdaddr_q;
        rddata_d   = rddata_q;
        load_err_d = 1'b0;

        if (accept) begin
            if (!bus.ex_isload) begin
                regwrite_d = rd_writable(bus.ex_regwrite, bus.ex_rd);
                rdaddr_d   = bus.ex_rd;
                rddata_d   = bus.ex_result;
            end else if (la_err) begin
                load_err_d = 1'b1;
            end else begin
                cap_d.rd       = bus.ex_rd;
                cap_d.regwrite = bus.ex_regwrite;
                cap_d.funct3   = bus.ex_funct3;
                cap_d.addr     = bus.ex_result;
            end
        end

        // Accept and response are mutually exclusive (IDLE vs WAIT), so the
        // write port is never claimed twice in one cycle.
        if ((state_q == WAIT) && bus.mem_rsp_valid) begin
            regwrite_d = rd_writable(cap_q.regwrite, cap_q.rd);
            rdaddr_d   = cap_q.rd;
            rddata_d   = la_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q      <= '0;
            regwrite_q <= 1'b0;
            rdaddr_q   <= '0;
            rddata_q   <= '0;
            load_err_q <= 1'b0;
        end else begin
            cap_q      <= cap_d;
            regwrite_q <= regwrite_d;
            rdaddr_q   <= rdaddr_d;
            rddata_q   <= rddata_d;
            load_err_q <= load_err_d;
        end
    end

    // ------------------------------------------------------------ outputs
    assign bus.ex_ready      = ex_ready;
    assign bus.mem_req_valid = mem_req_valid;
    assign bus.mem_addr      = {cap_q.addr[31:2], 2'b00};
    assign bus.regwrite      = regwrite_q;
    assign bus.rdaddr        = rdaddr_q;
    assign bus.rddata        = rddata_q;
    assign bus.pend_valid    = pend_valid;
    assign bus.pend_rd       = pend_rd;
    assign bus.load_err      = load_err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
// Directed scenarios with literal expectations, then randomized traffic, all
// compared every cycle against a transaction-level model of the stage.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_stage_if bus ();

    writeback_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned errors  = 0;
    int unsigned checks  = 0;
    bit          started = 1'b0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------- reference model
    function automatic bit m_legal(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned size;
        size = 1 << f3[1:0];
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        return (addr % size) == 0;
    endfunction

    function automatic logic [31:0] m_extract(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] word);
        logic [31:0] w;
        w = word >> (32'(addr % 4) * 8);
        case (f3)
            3'd0:    return {{24{w[7]}}, w[7:0]};
            3'd4:    return {24'd0, w[7:0]};
            3'd1:    return {{16{w[15]}}, w[15:0]};
            3'd5:    return {16'd0, w[15:0]};
            default: return word;
        endcase
    endfunction

    // Model: a load is "outstanding" from accept until its response; its
    // request is "issued" once memory took it. Expected pulses are per cycle.
    bit          m_busy = 1'b0;
    bit          m_reqd = 1'b0;
    logic [4:0]  l_rd   = '0;
    logic        l_we   = 1'b0;
    logic [2:0]  l_f3   = '0;
    logic [31:0] l_addr = '0;
    logic        m_we   = 1'b0;
    logic        m_err  = 1'b0;
    logic [4:0]  m_rd   = '0;
    logic [31:0] m_data = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_reqd <= 1'b0;
            m_we   <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            m_we  <= 1'b0;
            m_err <= 1'b0;
            if (!m_busy) begin
                if (bus.ex_valid) begin
                    if (!bus.ex_isload) begin
                        m_we   <= bus.ex_regwrite && (bus.ex_rd != 0);
                        m_rd   <= bus.ex_rd;
                        m_data <= bus.ex_result;
                    end else if (m_legal(bus.ex_funct3, bus.ex_result)) begin
                        m_busy <= 1'b1;
                        m_reqd <= 1'b0;
                        l_rd   <= bus.ex_rd;
                        l_we   <= bus.ex_regwrite;
                        l_f3   <= bus.ex_funct3;
                        l_addr <= bus.ex_result;
                    end else begin
                        m_err <= 1'b1;
                    end
                end
            end else if (!m_reqd) begin
                if (bus.mem_req_ready) m_reqd <= 1'b1;
            end else if (bus.mem_rsp_valid) begin
                m_we   <= l_we && (l_rd != 0);
                m_rd   <= l_rd;
                m_data <= m_extract(l_f3, l_addr, bus.mem_rsp_data);
                m_busy <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk1("ex_ready", bus.ex_ready, !m_busy && !rst);
            chk1("regwrite", bus.regwrite, m_we);
            chk1("load_err", bus.load_err, m_err);
            chk1("mem_req_valid", bus.mem_req_valid, m_busy && !m_reqd);
            chk1("pend_valid", bus.pend_valid, m_busy);
            if (m_we) begin
                chk32("rdaddr", 32'(bus.rdaddr), 32'(m_rd));
                chk32("rddata", bus.rddata, m_data);
            end
            if (m_busy) begin
                chk32("pend_rd", 32'(bus.pend_rd), 32'(l_rd));
                chk32("mem_addr", bus.mem_addr, {l_addr[31:2], 2'b00});
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.ex_valid      = 1'b0;
        bus.ex_isload     = 1'b0;
        bus.ex_regwrite   = 1'b0;
        bus.ex_rd         = '0;
        bus.ex_result     = '0;
        bus.ex_funct3     = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
    endtask

    task automatic do_nonload(input logic [4:0] rd, input logic [31:0] res, input logic we);
        bus.ex_valid    = 1'b1;
        bus.ex_isload   = 1'b0;
        bus.ex_regwrite = we;
        bus.ex_rd       = rd;
        bus.ex_result   = res;
        tick();
        bus.ex_valid = 1'b0;
        chk1("nl_regwrite", bus.regwrite, we && (rd != 0));
        chk32("nl_rdaddr", 32'(bus.rdaddr), 32'(rd));
        chk32("nl_rddata", bus.rddata, res);
    endtask

    task automatic do_badload(input logic [2:0] f3, input logic [31:0] addr);
        bus.ex_valid    = 1'b1;
        bus.ex_isload   = 1'b1;
        bus.ex_funct3   = f3;
        bus.ex_result   = addr;
        bus.ex_rd       = 5'd3;
        bus.ex_regwrite = 1'b1;
        tick();
        bus.ex_valid  = 1'b0;
        bus.ex_isload = 1'b0;
        chk1("bad_load_err", bus.load_err, 1'b1);
        chk1("bad_req", bus.mem_req_valid, 1'b0);
        chk1("bad_regwrite", bus.regwrite, 1'b0);
        tick();
        chk1("bad_err_pulse", bus.load_err, 1'b0);
        chk1("bad_req2", bus.mem_req_valid, 1'b0);
        chk1("bad_regwrite2", bus.regwrite, 1'b0);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] word, input int unsigned rdy_wait,
                           input int unsigned rsp_wait, input logic [31:0] exp);
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        bus.ex_valid    = 1'b1;
        bus.ex_isload   = 1'b1;
        bus.ex_funct3   = f3;
        bus.ex_result   = addr;
        bus.ex_rd       = rd;
        bus.ex_regwrite = 1'b1;
        tick();
        bus.ex_valid  = 1'b0;
        bus.ex_isload = 1'b0;
        chk1("ld_req", bus.mem_req_valid, 1'b1);
        chk32("ld_addr", bus.mem_addr, waddr);
        chk1("ld_pend", bus.pend_valid, 1'b1);
        chk32("ld_pend_rd", 32'(bus.pend_rd), 32'(rd));
        chk1("ld_ready", bus.ex_ready, 1'b0);
        chk1("ld_nowrite", bus.regwrite, 1'b0);
        for (int unsigned i = 0; i < rdy_wait; i++) begin
            bus.mem_rsp_valid = (i == 0);   // stray response during REQ
            bus.mem_rsp_data  = '1;
            tick();
            chk1("req_hold", bus.mem_req_valid, 1'b1);
            chk32("req_addr", bus.mem_addr, waddr);
            chk32("req_pend_rd", 32'(bus.pend_rd), 32'(rd));
            chk1("req_ready", bus.ex_ready, 1'b0);
            chk1("req_nowrite", bus.regwrite, 1'b0);
        end
        bus.mem_rsp_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        chk1("wait_req", bus.mem_req_valid, 1'b0);
        chk1("wait_pend", bus.pend_valid, 1'b1);
        chk32("wait_pend_rd", 32'(bus.pend_rd), 32'(rd));
        for (int unsigned i = 0; i < rsp_wait; i++) begin
            tick();
            chk1("wait_hold", bus.pend_valid, 1'b1);
            chk1("wait_ready", bus.ex_ready, 1'b0);
            chk1("wait_nowrite", bus.regwrite, 1'b0);
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = word;
        tick();
        bus.mem_rsp_valid = 1'b0;
        chk1("ld_regwrite", bus.regwrite, rd != 0);
        if (rd != 0) begin
            chk32("ld_rdaddr", 32'(bus.rdaddr), 32'(rd));
            chk32("ld_rddata", bus.rddata, exp);
        end
        chk1("ld_done_pend", bus.pend_valid, 1'b0);
        chk1("ld_done_ready", bus.ex_ready, 1'b1);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        started = 1'b1;
        tick();
        chk1("rst_regwrite", bus.regwrite, 1'b0);
        chk32("rst_rdaddr", 32'(bus.rdaddr), 32'd0);
        chk32("rst_rddata", bus.rddata, 32'd0);
        chk1("rst_load_err", bus.load_err, 1'b0);
        chk1("rst_req", bus.mem_req_valid, 1'b0);
        chk1("rst_pend", bus.pend_valid, 1'b0);
        chk32("rst_pend_rd", 32'(bus.pend_rd), 32'd0);
        chk32("rst_mem_addr", bus.mem_addr, 32'd0);
        chk1("rst_ex_ready", bus.ex_ready, 1'b0);
        rst = 1'b0;
        tick();

        // Non-loads, back to back, including rd=0 and regwrite=0
        do_nonload(5'd5, 32'hDEADBEEF, 1'b1);
        do_nonload(5'd0, 32'h11111111, 1'b1);
        do_nonload(5'd6, 32'h22222222, 1'b0);
        do_nonload(5'd31, 32'h0000_0001, 1'b1);
        idle_inputs();
        tick();

        // Load extraction, minimum latency
        do_load(3'b000, 32'h0000_0103, 5'd10, 32'h80FF_FFFF, 0, 0, 32'hFFFF_FF80);
        do_load(3'b100, 32'h0000_0103, 5'd11, 32'h80FF_FFFF, 0, 0, 32'h0000_0080);
        do_load(3'b001, 32'h0000_0102, 5'd12, 32'h8001_1234, 0, 0, 32'hFFFF_8001);
        do_load(3'b101, 32'h0000_0102, 5'd13, 32'h8001_1234, 0, 0, 32'h0000_8001);
        do_load(3'b010, 32'h0000_0200, 5'd14, 32'h1234_5678, 0, 0, 32'h1234_5678);
        // Non-load accepted in the cycle the load write pulses
        do_nonload(5'd15, 32'hCAFEF00D, 1'b1);
        // Load to x0 still accesses memory but never writes
        do_load(3'b010, 32'h0000_0200, 5'd0, 32'h1234_5678, 0, 0, 32'h1234_5678);
        idle_inputs();
        tick();

        // Misaligned / illegal loads
        do_badload(3'b010, 32'h0000_0201);
        do_badload(3'b001, 32'h0000_0101);
        do_badload(3'b011, 32'h0000_0100);
        do_badload(3'b111, 32'h0000_0100);

        // Slow memory: ready after 3 cycles, response 4 cycles later
        do_load(3'b000, 32'h0000_0301, 5'd9, 32'h0000_7F00, 3, 4, 32'h0000_007F);
        idle_inputs();
        tick();

        // Reset while waiting for the response abandons the load
        bus.ex_valid    = 1'b1;
        bus.ex_isload   = 1'b1;
        bus.ex_funct3   = 3'b010;
        bus.ex_result   = 32'h0000_0400;
        bus.ex_rd       = 5'd20;
        bus.ex_regwrite = 1'b1;
        tick();
        bus.ex_valid      = 1'b0;
        bus.ex_isload     = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        chk1("rw_pend", bus.pend_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk1("rw_ready_in_rst", bus.ex_ready, 1'b0);
        tick();
        rst = 1'b0;
        chk1("rw_pend_cleared", bus.pend_valid, 1'b0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'hABCD_EF01;
        tick();
        bus.mem_rsp_valid = 1'b0;
        chk1("rw_no_write", bus.regwrite, 1'b0);
        do_nonload(5'd21, 32'h5555_AAAA, 1'b1);
        idle_inputs();
        tick();

        // Randomized traffic
        for (int unsigned n = 0; n < 3000; n++) begin
            rst               = ($urandom_range(0, 199) == 0);
            bus.ex_valid      = ($urandom_range(0, 3) != 0);
            bus.ex_isload     = ($urandom_range(0, 9) < 4);
            bus.ex_funct3     = 3'($urandom_range(0, 7));
            bus.ex_result     = $urandom;
            bus.ex_rd         = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.ex_regwrite   = ($urandom_range(0, 7) != 0);
            bus.mem_req_ready = ($urandom_range(0, 1) != 0);
            bus.mem_rsp_valid = ($urandom_range(0, 2) == 0);
            bus.mem_rsp_data  = $urandom;
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
